// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and state types for the calculator serial link
// Ports: none (package).
package calc_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int         MAX_LEN    = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    MSG_IDLE,
    MSG_COLLECT
  } msg_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_ZERO + 8'd9);
  endfunction

endpackage

// File: rtl/receive_number_if.sv
// rtl/receive_number_if.sv - serial input and published-number bundle of receive_number
// Signals:
//   rxd              UART line into the receiver, idle high
//   num1..num4       last four digits, num4 newest
//   value            eight BCD digits, [3:0] newest
//   len              digit count of the last message
//   done             one-cycle pulse when the outputs update
//   busy             a message is open
//   ferr/badChar/overflow  sticky flags of the last message
// Modports: master = receive_number side, slave = line driver / result consumer.
interface receive_number_if;

  logic        rxd;
  logic [3:0]  num1;
  logic [3:0]  num2;
  logic [3:0]  num3;
  logic [3:0]  num4;
  logic [31:0] value;
  logic [3:0]  len;
  logic        done;
  logic        busy;
  logic        ferr;
  logic        badChar;
  logic        overflow;

  modport master (
    input  rxd,
    output num1, num2, num3, num4, value, len, done, busy, ferr, badChar, overflow
  );

  modport slave (
    output rxd,
    input  num1, num2, num3, num4, value, len, done, busy, ferr, badChar, overflow
  );

endinterface

// File: rtl/receive_data.sv
// rtl/receive_data.sv - 8N1 UART byte receiver with input synchroniser
// Ports:
//   clk, reset (async, active low)
//   rxd        asynchronous serial input, idle high
//   byteValid  one-cycle pulse, byteData holds a byte with a good stop bit
//   byteErr    one-cycle pulse, stop bit sampled low (byte discarded)
//   byteData   last good byte
module receive_data
  import calc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byteValid,
  output logic       byteErr,
  output logic [7:0] byteData
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          valid_n;
  logic          err_n;
  logic [7:0]    data_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byteValid <= 1'b0;
      byteErr   <= 1'b0;
      byteData  <= '0;
    end else begin
      rx_meta   <= rxd;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      byteValid <= valid_n;
      byteErr   <= err_n;
      byteData  <= data_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + CW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    data_n    = byteData;
    case (state)
      RX_IDLE: begin
        clk_cnt_n = '0;
        // Returning here at the stop-bit mid-sample leaves half a bit to
        // catch the next start edge, so back-to-back bytes are not lost.
        if (rx_prev && !rx_sync) state_n = RX_START;
      end
      RX_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          shreg_n   = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          state_n   = RX_IDLE;
          if (rx_sync) begin
            valid_n = 1'b1;
            data_n  = shreg;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/receive_number.sv
// rtl/receive_number.sv - assembles received ASCII digits into an 8-digit BCD number
// Ports:
//   clk, reset (async, active low)
//   bus  receive_number_if.master: rxd in; num1..num4, value, len, done,
//        busy, ferr, badChar, overflow out
module receive_number
  import calc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT      = 20 * CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  receive_number_if.master bus
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] EXPIRE_AT = TW'(TIMEOUT - 1);
  localparam logic [3:0]    LEN_MAX   = 4'(MAX_LEN);

  logic          byte_valid;
  logic          byte_err;
  logic [7:0]    byte_data;
  logic          byte_evt;
  logic          digit_ok;
  logic          expire;

  msg_state_t    msg_state;
  msg_state_t    msg_next;
  logic [TW-1:0] idle_cnt;

  logic [31:0]   work_digits, base_digits, digits_n;
  logic [3:0]    work_cnt, base_cnt, cnt_n;
  logic          work_ferr, base_ferr, ferr_n;
  logic          work_bad, base_bad, bad_n;
  logic          work_ovf, base_ovf, ovf_n;

  logic [31:0]   value_q;
  logic [3:0]    len_q;
  logic          done_q;
  logic          ferr_q;
  logic          bad_q;
  logic          ovf_q;

  receive_data #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_receive_data (
    .clk      (clk),
    .reset    (reset),
    .rxd      (bus.rxd),
    .byteValid(byte_valid),
    .byteErr  (byte_err),
    .byteData (byte_data)
  );

  always_comb begin
    byte_evt = byte_valid | byte_err;
    digit_ok = byte_valid && is_digit(byte_data);

    // The byte that opens a message is applied to an empty buffer.
    if (msg_state == MSG_IDLE) begin
      base_digits = '0;
      base_cnt    = '0;
      base_ferr   = 1'b0;
      base_bad    = 1'b0;
      base_ovf    = 1'b0;
    end else begin
      base_digits = work_digits;
      base_cnt    = work_cnt;
      base_ferr   = work_ferr;
      base_bad    = work_bad;
      base_ovf    = work_ovf;
    end

    digits_n = base_digits;
    cnt_n    = base_cnt;
    ferr_n   = base_ferr | byte_err;
    bad_n    = base_bad | (byte_valid && !digit_ok);
    ovf_n    = base_ovf;
    if (digit_ok) begin
      digits_n = {base_digits[27:0], byte_data[3:0]};
      if (base_cnt == LEN_MAX) ovf_n = 1'b1;
      else                     cnt_n = base_cnt + 4'd1;
    end

    // idle_cnt counts cycles since the last byte cycle, so done lands
    // exactly TIMEOUT cycles after it; a byte on the deciding edge wins.
    expire = (msg_state == MSG_COLLECT) && !byte_evt && (idle_cnt == EXPIRE_AT);

    msg_next = msg_state;
    case (msg_state)
      MSG_IDLE:    if (byte_evt) msg_next = MSG_COLLECT;
      MSG_COLLECT: if (expire)   msg_next = MSG_IDLE;
      default:     msg_next = MSG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_state   <= MSG_IDLE;
      idle_cnt    <= '0;
      work_digits <= '0;
      work_cnt    <= '0;
      work_ferr   <= 1'b0;
      work_bad    <= 1'b0;
      work_ovf    <= 1'b0;
      value_q     <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      msg_state <= msg_next;
      done_q    <= expire;
      if (byte_evt) begin
        work_digits <= digits_n;
        work_cnt    <= cnt_n;
        work_ferr   <= ferr_n;
        work_bad    <= bad_n;
        work_ovf    <= ovf_n;
        idle_cnt    <= TW'(1);
      end else if (msg_state == MSG_COLLECT) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
      if (expire) begin
        value_q <= work_digits;
        len_q   <= work_cnt;
        ferr_q  <= work_ferr;
        bad_q   <= work_bad;
        ovf_q   <= work_ovf;
      end
    end
  end

  assign bus.value    = value_q;
  assign bus.num1     = value_q[15:12];
  assign bus.num2     = value_q[11:8];
  assign bus.num3     = value_q[7:4];
  assign bus.num4     = value_q[3:0];
  assign bus.len      = len_q;
  assign bus.done     = done_q;
  assign bus.busy     = (msg_state == MSG_COLLECT);
  assign bus.ferr     = ferr_q;
  assign bus.badChar  = bad_q;
  assign bus.overflow = ovf_q;

endmodule
